mmss_counter_periph: RTL and testbench
======================================

# mmss_counter_periph

Memory-mapped MM:SS time-keeping peripheral on the picosoc `iomem` bus, page `0x05`. It keeps a BCD minutes:seconds count in hardware and drives the 16-bit value that the seven-segment display mux consumes, so firmware no longer has to push `gpio[15:0]` every second. It also generates the colon blink. Count direction comes from the board's `UP_DOWN` pin or from a firmware override bit.

## Interface

**Parameters**
- `CLK_HZ`, default 16000000: clock frequency. Sets the 1 Hz prescaler reload value, `CLK_HZ-1`.
- `DEBOUNCE_CYCLES`, default 16000: number of consecutive stable cycles the direction pin must hold before a change is accepted (1 ms at 16 MHz).
- `ADDR_PAGE`, default 8'h05: peripheral select, matched against `iomem_addr[31:24]`.

**Ports**
- `clk`, in, 1: single system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `iomem_valid`, in, 1: bus request.
- `iomem_ready`, out, 1: one-cycle acknowledge.
- `iomem_wstrb`, in, 4: byte write strobes; 0 means a read.
- `iomem_addr`, in, 32: byte address.
- `iomem_wdata`, in, 32: write data.
- `iomem_rdata`, out, 32: read data, valid while `iomem_ready` is high.
- `up_down`, in, 1: asynchronous pin; 1 means count up.
- `disp_value`, out, 16: BCD digits `{M1,M0,S1,S0}`.
- `colon`, out, 1: toggles every 0.5 s while running.

## Operation

**Registers** (`iomem_addr[3:2]`; writes use whole-word semantics when any strobe is set)
- `0x0` CTRL, reset 0, read/write:
  - bit0 `run`
  - bit1 `dir_ovr`: when 1, `dir_reg` is used instead of the pin
  - bit2 `dir_reg`
- `0x4` VALUE, reset 0:
  - read returns `{16'h0, disp_value}`.
  - write loads `wdata[15:0]` only if every nibble is legal (S0, M0 ≤ 9; S1, M1 ≤ 5).
  - an illegal write leaves the count unchanged and sets `STATUS.err`.
- `0x8` STATUS:
  - bit0 `dir_eff`, read-only
  - bit1 `wrap`, sticky, write-1-to-clear
  - bit2 `err`, sticky, write-1-to-clear
- `0xC`: reads 0, writes are ignored.

**Bus handshake**
- An access is accepted when `iomem_valid && !iomem_ready && addr[31:24]==ADDR_PAGE`.
- On the next edge `iomem_ready` is 1 for exactly one cycle, with `iomem_rdata` loaded on the same edge. It then returns to 0.
- A page mismatch never asserts `iomem_ready`.

**Counting**
- The prescaler counts down from `CLK_HZ-1` only while `run`=1.
- When it reaches 0 it produces a 1-cycle `tick` and reloads.
- When `run`=0 the prescaler holds its value and `colon` holds.
- Up (`dir_eff`=1), on each tick:
  - S0 9→0 carries into S1.
  - S1 5→0 carries into M0.
  - M0 9→0 carries into M1.
  - 59:59 → 00:00 and sets `wrap`.
- Down: the mirror image. 00:00 → 59:59 and sets `wrap`.
- `dir_eff = dir_ovr ? dir_reg : dir_filtered`.
- `colon` toggles when the prescaler passes `CLK_HZ/2` and again at 0, giving a 1 Hz, 50% duty blink.

**Boundary and priority rules**
- A VALUE write and a tick in the same cycle: the write wins, the tick is dropped, and the prescaler reloads.
- A STATUS W1C and a `wrap` set event in the same cycle: the set wins.
- Setting `run` 0→1 reloads the prescaler, so the first tick comes `CLK_HZ` cycles later.
- `reset` asserted at any time, including mid-access: all state clears immediately and `iomem_ready` drops without completing the access.

## Timing

- Reset values:
  - `iomem_ready`=0, `iomem_rdata`=0
  - `disp_value`=16'h0000, `colon`=0
  - prescaler = `CLK_HZ-1`
  - CTRL = 0, STATUS sticky bits = 0
  - direction filter output = 1
- Bus latency: 1 cycle from accepted request to `iomem_ready`. Back-to-back accesses occur at most every 2 cycles.
- Count latency: `disp_value` updates on the edge after the prescaler is 0. A VALUE write is visible on `disp_value` on the same edge that raises `iomem_ready`.
- Direction pin: goes through a 2-flop synchronizer plus the debouncer. A change takes `2+DEBOUNCE_CYCLES` cycles to reach `dir_eff`.

## Configuration

- `MMSS_DEBOUNCE_EN` defined: the `DEBOUNCE_CYCLES` stability filter is placed after the synchronizer.
- Not defined: only the 2-flop synchronizer is used, with 2-cycle latency. `DEBOUNCE_CYCLES` is unused.

## Structure

- Package `mmss_pkg` holds:
  - register offsets (`MMSS_CTRL`, `MMSS_VALUE`, `MMSS_STATUS`)
  - CTRL and STATUS bit positions
  - BCD limits 9 and 5
  - a `bcd_legal` function
- Sub-module `mmss_dir_filter` contains the synchronizer and the optional debouncer. The top level contains the bus decode, prescaler and BCD chain.

## Test plan

- **Wrap up:** write VALUE=0x5958, set CTRL=0x1 with `up_down`=1, wait 2 ticks → `disp_value` goes 0x5959 then 0x0000, and STATUS reads 0x3.
- **Illegal load:** write VALUE=0x1A00 → `disp_value` unchanged, STATUS.err=1. Writing STATUS=0x4 clears it.
- **Override down:** CTRL=0x3 (run, override, dir_reg=0) with the pin held 1 and VALUE=0x0000 → after 1 tick `disp_value`=0x5959 and `wrap`=1.
- **Write/tick collision:** issue a VALUE write of 0x1234 on the prescaler-zero cycle → `disp_value`=0x1234, with no increment until `CLK_HZ` cycles later.
- **Debounce** (`MMSS_DEBOUNCE_EN`): a `up_down` glitch of `DEBOUNCE_CYCLES-1` cycles → `dir_eff` unchanged. A stable change → `dir_eff` flips after `2+DEBOUNCE_CYCLES` cycles.
- **Reset mid-access:** assert `reset` the cycle after `iomem_valid` → `iomem_ready`=0 and all outputs return to their reset values immediately.

Source files
------------

// File: rtl/mmss_pkg.sv
// mmss_pkg: shared definitions for the MM:SS counter peripheral.
// Register word offsets (iomem_addr[3:2]), CTRL/STATUS bit positions,
// BCD digit limits, the CTRL register layout and a BCD legality check.
package mmss_pkg;

    localparam int unsigned REG_IDX_W = 2;
    localparam int unsigned BCD_W     = 4;

    localparam logic [REG_IDX_W-1:0] MMSS_CTRL   = 2'd0;
    localparam logic [REG_IDX_W-1:0] MMSS_VALUE  = 2'd1;
    localparam logic [REG_IDX_W-1:0] MMSS_STATUS = 2'd2;

    localparam int unsigned CTRL_RUN_BIT     = 0;
    localparam int unsigned CTRL_DIR_OVR_BIT = 1;
    localparam int unsigned CTRL_DIR_REG_BIT = 2;

    localparam int unsigned STAT_DIR_BIT  = 0;
    localparam int unsigned STAT_WRAP_BIT = 1;
    localparam int unsigned STAT_ERR_BIT  = 2;

    localparam logic [BCD_W-1:0] BCD_MAX_UNITS = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MAX_TENS  = 4'd5;

    // CTRL register contents, bit 0 = run
    typedef struct packed {
        logic dir_reg;
        logic dir_ovr;
        logic run;
    } ctrl_t;

    // True when {M1,M0,S1,S0} is a valid MM:SS value
    function automatic logic bcd_legal(input logic [15:0] v);
        return (v[3:0]   <= BCD_MAX_UNITS) &&
               (v[7:4]   <= BCD_MAX_TENS)  &&
               (v[11:8]  <= BCD_MAX_UNITS) &&
               (v[15:12] <= BCD_MAX_TENS);
    endfunction

endpackage

// File: rtl/mmss_dir_filter.sv
// mmss_dir_filter: conditions the asynchronous UP_DOWN pin.
// Two-flop synchronizer, optionally followed by a stability filter that only
// accepts a new level after DEBOUNCE_CYCLES consecutive cycles.
// Build option: MMSS_DEBOUNCE_EN enables the stability filter; otherwise the
// output is the synchronizer output (2-cycle latency).
// Ports:
//   clk          - system clock
//   reset        - asynchronous active-high reset (output resets to 1 = up)
//   pin          - raw direction pin
//   dir_filtered - conditioned direction, 1 = count up
module mmss_dir_filter
    import mmss_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16000
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic dir_filtered
);

    logic sync_meta;
    logic sync_out;

    // Metastability synchronizer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_out  <= 1'b1;
        end else begin
            sync_meta <= pin;
            sync_out  <= sync_meta;
        end
    end

`ifdef MMSS_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] stable_cnt;

    // Counts cycles the synchronized pin disagrees with the output; any
    // agreement restarts the count, so glitches shorter than the window vanish.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_filtered <= 1'b1;
            stable_cnt   <= '0;
        end else if (sync_out == dir_filtered) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_LAST) begin
            dir_filtered <= sync_out;
            stable_cnt   <= '0;
        end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
        end
    end
`else
    localparam int unsigned unused_debounce = DEBOUNCE_CYCLES;

    assign dir_filtered = sync_out;
`endif

endmodule

// File: rtl/mmss_counter_periph.sv
// mmss_counter_periph: memory-mapped BCD MM:SS counter for the picosoc iomem bus.
// Registers (iomem_addr[3:2]): 0x0 CTRL {dir_reg,dir_ovr,run}, 0x4 VALUE,
// 0x8 STATUS {err,wrap,dir_eff}, 0xC reserved (reads 0).
// Build option: MMSS_DEBOUNCE_EN adds the direction-pin stability filter.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   iomem_valid/ready          - request / one-cycle acknowledge
//   iomem_wstrb                - byte strobes, 0 = read (any strobe = full write)
//   iomem_addr/wdata/rdata     - address, write data, read data
//   up_down                    - asynchronous direction pin, 1 = up
//   disp_value                 - BCD {M1,M0,S1,S0} for the display mux
//   colon                      - 1 Hz 50% blink while running
module mmss_counter_periph
    import mmss_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 16000000,
    parameter int unsigned DEBOUNCE_CYCLES = 16000,
    parameter logic [7:0]  ADDR_PAGE       = 8'h05
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic        up_down,
    output logic [15:0] disp_value,
    output logic        colon
);

    localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_HALF   = PRE_W'(CLK_HZ / 2);

    ctrl_t                ctrl;
    logic [PRE_W-1:0]     prescaler;
    logic                 wrap;
    logic                 err;
    logic                 dir_filtered;

    logic                 accept_c;
    logic                 wr_c;
    logic [REG_IDX_W-1:0] reg_idx_c;
    logic                 wr_ctrl_c;
    logic                 wr_value_c;
    logic                 wr_status_c;
    logic                 value_ok_c;
    logic                 tick_c;
    logic                 run_rise_c;
    logic                 dir_eff_c;
    ctrl_t                ctrl_wdata_c;
    logic [31:0]          rdata_c;
    logic [15:0]          step_c;
    logic                 wrap_c;
    logic [BCD_W-1:0]     dig_c;
    logic [BCD_W-1:0]     lim_c;
    logic                 unused_bus_bits;

    assign unused_bus_bits = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:16]};

    mmss_dir_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dir_filter (
        .clk          (clk),
        .reset        (reset),
        .pin          (up_down),
        .dir_filtered (dir_filtered)
    );

    // Bus decode; the !iomem_ready term spaces accesses two cycles apart
    assign accept_c    = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_PAGE);
    assign wr_c        = accept_c && (iomem_wstrb != 4'b0000);
    assign reg_idx_c   = iomem_addr[3:2];
    assign wr_ctrl_c   = wr_c && (reg_idx_c == MMSS_CTRL);
    assign wr_value_c  = wr_c && (reg_idx_c == MMSS_VALUE);
    assign wr_status_c = wr_c && (reg_idx_c == MMSS_STATUS);
    assign value_ok_c  = bcd_legal(iomem_wdata[15:0]);

    assign ctrl_wdata_c.run     = iomem_wdata[CTRL_RUN_BIT];
    assign ctrl_wdata_c.dir_ovr = iomem_wdata[CTRL_DIR_OVR_BIT];
    assign ctrl_wdata_c.dir_reg = iomem_wdata[CTRL_DIR_REG_BIT];

    assign tick_c     = ctrl.run && (prescaler == '0);
    assign run_rise_c = wr_ctrl_c && ctrl_wdata_c.run && !ctrl.run;
    assign dir_eff_c  = ctrl.dir_ovr ? ctrl.dir_reg : dir_filtered;

    // Read mux
    always_comb begin
        rdata_c = '0;
        case (reg_idx_c)
            MMSS_CTRL:   rdata_c[2:0]  = ctrl;
            MMSS_VALUE:  rdata_c[15:0] = disp_value;
            MMSS_STATUS: begin
                rdata_c[STAT_DIR_BIT]  = dir_eff_c;
                rdata_c[STAT_WRAP_BIT] = wrap;
                rdata_c[STAT_ERR_BIT]  = err;
            end
            default:     rdata_c = '0;
        endcase
    end

    // Next BCD value: ripple carry/borrow from S0 up to M1; a carry out of M1
    // is the 59:59 <-> 00:00 wrap
    always_comb begin
        step_c = disp_value;
        wrap_c = 1'b1;
        dig_c  = '0;
        lim_c  = '0;
        for (int i = 0; i < 4; i++) begin
            dig_c = disp_value[i*4 +: 4];
            lim_c = (i % 2 == 0) ? BCD_MAX_UNITS : BCD_MAX_TENS;
            if (wrap_c) begin
                if (dir_eff_c) begin
                    if (dig_c == lim_c) begin
                        dig_c = '0;
                    end else begin
                        dig_c  = dig_c + 4'd1;
                        wrap_c = 1'b0;
                    end
                end else begin
                    if (dig_c == '0) begin
                        dig_c = lim_c;
                    end else begin
                        dig_c  = dig_c - 4'd1;
                        wrap_c = 1'b0;
                    end
                end
            end
            step_c[i*4 +: 4] = dig_c;
        end
    end

    // Bus response, registers, prescaler and counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            ctrl        <= '0;
            prescaler   <= PRE_RELOAD;
            disp_value  <= '0;
            colon       <= 1'b0;
            wrap        <= 1'b0;
            err         <= 1'b0;
        end else begin
            iomem_ready <= accept_c;
            if (accept_c) begin
                iomem_rdata <= rdata_c;
            end

            if (wr_ctrl_c) begin
                ctrl <= ctrl_wdata_c;
            end

            // Reload on start so the first tick is a full second away
            if (run_rise_c) begin
                prescaler <= PRE_RELOAD;
            end else if (ctrl.run) begin
                prescaler <= (prescaler == '0) ? PRE_RELOAD : prescaler - PRE_W'(1);
            end

            if (ctrl.run && ((prescaler == PRE_HALF) || (prescaler == '0))) begin
                colon <= ~colon;
            end

            // A VALUE write in the tick cycle swallows the tick
            if (wr_value_c) begin
                if (value_ok_c) begin
                    disp_value <= iomem_wdata[15:0];
                end
            end else if (tick_c) begin
                disp_value <= step_c;
            end

            if (wr_value_c && !value_ok_c) begin
                err <= 1'b1;
            end else if (wr_status_c && iomem_wdata[STAT_ERR_BIT]) begin
                err <= 1'b0;
            end

            // Set beats write-1-to-clear
            if (tick_c && !wr_value_c && wrap_c) begin
                wrap <= 1'b1;
            end else if (wr_status_c && iomem_wdata[STAT_WRAP_BIT]) begin
                wrap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmss_counter_periph.sv
// tb_mmss_counter_periph: self-checking bench for mmss_counter_periph.
// Register vectors come from a table; bus read data is checked through a
// scoreboard queue filled when a request is driven and drained on iomem_ready.
`timescale 1ns/1ps
module tb_mmss_counter_periph;

    localparam int unsigned CLK_HZ = 20;
    localparam int unsigned DEB    = 6;
`ifdef MMSS_DEBOUNCE_EN
    localparam int unsigned LAT = DEB;
`else
    localparam int unsigned LAT = 0;
`endif
    localparam logic [31:0] PAGE_BASE = 32'h0500_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        up_down;
    logic [15:0] disp_value;
    logic        colon;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        chk;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        logic [3:0]  strb;
        logic [3:0]  off;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    mmss_counter_periph #(
        .CLK_HZ          (CLK_HZ),
        .DEBOUNCE_CYCLES (DEB),
        .ADDR_PAGE       (8'h05)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .up_down     (up_down),
        .disp_value  (disp_value),
        .colon       (colon)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard drain: one entry per acknowledged access
    always @(negedge clk) begin : monitor
        sb_t e;
        if (iomem_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_ready: ready=1 with no request outstanding");
            end else begin
                e = sb_q.pop_front();
                if (e.chk) check(e.name, iomem_rdata, e.exp);
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge where ready is seen
    task automatic bus_access(input string name, input logic [3:0] strb, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic chk, input logic [31:0] exp);
        sb_t e;
        bit  done;
        e.name = name;
        e.chk  = chk;
        e.exp  = exp;
        sb_q.push_back(e);
        iomem_valid = 1'b1;
        iomem_wstrb = strb;
        iomem_addr  = addr;
        iomem_wdata = wdata;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (iomem_ready === 1'b1) done = 1'b1;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: ready not seen within 8 cycles", name);
            if (sb_q.size() != 0) void'(sb_q.pop_back());
        end
    endtask

    task automatic rd(input string name, input logic [3:0] off, input logic [31:0] exp);
        bus_access(name, 4'b0000, PAGE_BASE | 32'(off), 32'h0, 1'b1, exp);
    endtask

    task automatic wr(input string name, input logic [3:0] off, input logic [31:0] data);
        bus_access(name, 4'b1111, PAGE_BASE | 32'(off), data, 1'b0, 32'h0);
    endtask

    task automatic add_vec(input string name, input logic [3:0] strb, input logic [3:0] off,
                           input logic [31:0] wdata, input logic chk, input logic [31:0] exp);
        vec_t v;
        v.name = name; v.strb = strb; v.off = off; v.wdata = wdata; v.chk = chk; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ready_seen;

        // name, strb, offset, wdata, check, expected rdata
        add_vec("ctrl_rst",      4'h0, 4'h0, 32'h0,         1'b1, 32'h0);
        add_vec("value_rst",     4'h0, 4'h4, 32'h0,         1'b1, 32'h0);
        add_vec("status_rst",    4'h0, 4'h8, 32'h0,         1'b1, 32'h1);
        add_vec("regc_rst",      4'h0, 4'hC, 32'h0,         1'b1, 32'h0);
        add_vec("wr_value",      4'hF, 4'h4, 32'h1234,      1'b0, 32'h0);
        add_vec("value_1234",    4'h0, 4'h4, 32'h0,         1'b1, 32'h1234);
        add_vec("wr_value_bad",  4'h1, 4'h4, 32'h1A00,      1'b0, 32'h0);
        add_vec("value_keep",    4'h0, 4'h4, 32'h0,         1'b1, 32'h1234);
        add_vec("status_err",    4'h0, 4'h8, 32'h0,         1'b1, 32'h5);
        add_vec("wr_err_clr",    4'hF, 4'h8, 32'h4,         1'b0, 32'h0);
        add_vec("status_clr",    4'h0, 4'h8, 32'h0,         1'b1, 32'h1);
        add_vec("wr_value_bad2", 4'h8, 4'h4, 32'h6000,      1'b0, 32'h0);
        add_vec("value_keep2",   4'h0, 4'h4, 32'h0,         1'b1, 32'h1234);
        add_vec("status_err2",   4'h0, 4'h8, 32'h0,         1'b1, 32'h5);
        add_vec("wr_stat_clr",   4'hF, 4'h8, 32'h6,         1'b0, 32'h0);
        add_vec("wr_value_hi",   4'h2, 4'h4, 32'hFFFF0959,  1'b0, 32'h0);
        add_vec("value_0959",    4'h0, 4'h4, 32'h0,         1'b1, 32'h0959);
        add_vec("status_ok",     4'h0, 4'h8, 32'h0,         1'b1, 32'h1);
        add_vec("wr_ctrl_ovr_up",4'hF, 4'h0, 32'h6,         1'b0, 32'h0);
        add_vec("ctrl_6",        4'h0, 4'h0, 32'h0,         1'b1, 32'h6);
        add_vec("status_ovr_up", 4'h0, 4'h8, 32'h0,         1'b1, 32'h1);
        add_vec("wr_ctrl_ovr_dn",4'hF, 4'h0, 32'h2,         1'b0, 32'h0);
        add_vec("status_ovr_dn", 4'h0, 4'h8, 32'h0,         1'b1, 32'h0);
        add_vec("wr_regc",       4'hF, 4'hC, 32'hFFFFFFFF,  1'b0, 32'h0);
        add_vec("regc",          4'h0, 4'hC, 32'h0,         1'b1, 32'h0);
        add_vec("wr_ctrl_hi",    4'hF, 4'h0, 32'hFFFFFFF8,  1'b0, 32'h0);
        add_vec("ctrl_hi",       4'h0, 4'h0, 32'h0,         1'b1, 32'h0);

        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        up_down     = 1'b1;
        wait_neg(3);
        check("rst_ready", 32'(iomem_ready), 32'h0);
        check("rst_rdata", iomem_rdata, 32'h0);
        check("rst_disp",  32'(disp_value), 32'h0);
        check("rst_colon", 32'(colon), 32'h0);
        reset = 1'b0;
        wait_neg(2);

        foreach (vecs[i])
            bus_access(vecs[i].name, vecs[i].strb, PAGE_BASE | 32'(vecs[i].off),
                       vecs[i].wdata, vecs[i].chk, vecs[i].exp);

        // Foreign page must never be acknowledged
        wait_neg(1);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0600_0004;
        ready_seen  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (iomem_ready === 1'b1) ready_seen++;
        end
        iomem_valid = 1'b0;
        check("page_mismatch_ready", 32'(ready_seen), 32'h0);
        wait_neg(1);

        // Count up through 59:59 -> 00:00, colon timing, wrap flag
        wr("wrap_value", 4'h4, 32'h5958);
        wr("wrap_run",   4'h0, 32'h1);
        wait_neg(9);  check("colon_before_half", 32'(colon), 32'h0);
        wait_neg(1);  check("colon_at_half",     32'(colon), 32'h1);
        wait_neg(9);  check("up_before_tick",    32'(disp_value), 32'h5958);
        wait_neg(1);  check("up_tick1",          32'(disp_value), 32'h5959);
                      check("colon_at_tick",     32'(colon), 32'h0);
        wait_neg(19); check("up_before_tick2",   32'(disp_value), 32'h5959);
        wait_neg(1);  check("up_wrap",           32'(disp_value), 32'h0000);
        rd("status_wrap_up", 4'h8, 32'h3);
        wr("wrap_clr",       4'h8, 32'h2);
        rd("status_wrap_clr", 4'h8, 32'h1);
        wr("stop1",          4'h0, 32'h0);
        wait_neg(30); check("hold_when_stopped", 32'(disp_value), 32'h0000);

        // Override direction down with the pin still high
        wr("dn_value", 4'h4, 32'h0000);
        wr("dn_run",   4'h0, 32'h3);
        wait_neg(19); check("dn_before_tick", 32'(disp_value), 32'h0000);
        wait_neg(1);  check("dn_wrap",        32'(disp_value), 32'h5959);
        rd("status_wrap_dn", 4'h8, 32'h2);
        wr("dn_clr",  4'h8, 32'h2);
        wr("stop2",   4'h0, 32'h0);

        // VALUE write on the prescaler-zero cycle drops the tick
        wr("col_value", 4'h4, 32'h0100);
        wr("col_run",   4'h0, 32'h1);
        wait_neg(19); check("col_pre", 32'(disp_value), 32'h0100);
        wr("col_write", 4'h4, 32'h1234);
        check("col_write_wins", 32'(disp_value), 32'h1234);
        wait_neg(19); check("col_no_early_tick", 32'(disp_value), 32'h1234);
        wait_neg(1);  check("col_next_tick",     32'(disp_value), 32'h1235);
        wr("stop3", 4'h0, 32'h0);
        rd("col_status", 4'h8, 32'h1);

        // Direction pin latency through the filter
        wait_neg(1);
        up_down = 1'b0;
        wait_neg(1 + LAT);
        rd("dir_not_yet", 4'h8, 32'h1);
        rd("dir_flipped", 4'h8, 32'h0);
        up_down = 1'b1;
        wait_neg(LAT + 4);
        rd("dir_back_up", 4'h8, 32'h1);
`ifdef MMSS_DEBOUNCE_EN
        up_down = 1'b0;
        wait_neg(DEB - 1);
        up_down = 1'b1;
        wait_neg(DEB + 4);
        rd("dir_glitch_ignored", 4'h8, 32'h1);
`endif

        // Reset in the middle of an access
        wr("mid_value", 4'h4, 32'h4321);
        wr("mid_bad",   4'h4, 32'h00AA);
        wr("mid_run",   4'h0, 32'h1);
        wait_neg(2);
        iomem_valid = 1'b1;
        iomem_wstrb = 4'b0000;
        iomem_addr  = PAGE_BASE | 32'h4;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(iomem_ready), 32'h0);
        check("mid_rst_rdata", iomem_rdata, 32'h0);
        check("mid_rst_disp",  32'(disp_value), 32'h0);
        check("mid_rst_colon", 32'(colon), 32'h0);
        iomem_valid = 1'b0;
        wait_neg(2);
        reset = 1'b0;
        wait_neg(1);
        rd("post_rst_ctrl",   4'h0, 32'h0);
        rd("post_rst_status", 4'h8, 32'h1);
        rd("post_rst_value",  4'h4, 32'h0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
